reset_status: RTL and testbench
===============================

# reset_status

Peripheral-side companion to the software reset controller. Takes the ten per-peripheral reset requests that controller drives and stretches each deassertion to a guaranteed minimum hold time. Exposes a CPU-readable status, sticky-completion and event-count register file on the same byte-swapped bus convention the controller uses for writes. Sits between the reset controller outputs and the peripherals' reset inputs.

## Interface
- HOLD_CYCLES, 16, minimum cycles each rst_out bit stays high after its request drops; legal range 1..255
- clk  input  1  system clock
- rst_globl  input  1  global reset; synchronous, active-high
- rst_req  input  10  reset requests; bit order [9:0] = gpio, uart, sdcard, video, usb, psram, interrupt, sb, timer, mmu
- rst_out  output  10  stretched resets to peripherals, same bit order
- a  input  3  register select
- d  input  32  write data, bus byte order
- we  input  1  write strobe; one write per cycle it is high
- spo  output  32  read data, bus byte order, combinational from a
- irq  output  1  completion interrupt; present only with RESET_STATUS_IRQ_EN

## Operation
- Bus byte order is reversed relative to internal words on both paths:
  - internal = {d[7:0], d[15:8], d[23:16], d[31:24]}
  - spo is the same swap of the internal read word
- Per-channel FSM with three states:
  - IDLE (rst_out=0): req=1 -> ASSERT; event counter credited.
  - ASSERT (rst_out=1): req=0 -> HOLD, cnt <= HOLD_CYCLES-1.
  - HOLD (rst_out=1):
    - req=1 -> ASSERT, no event credit.
    - else cnt==0 -> IDLE and set done[i].
    - else cnt <= cnt-1.
- Counter width is clog2(HOLD_CYCLES+1), one counter per channel.
- Registers (internal word view; unused bits read 0):
  - a=0 STATUS [9:0]: current rst_out. Read-only; writes ignored.
  - a=1 DONE [9:0]: sticky completion flags. Writing 1 to a bit clears it. If a set and a clear of the same bit land in the same cycle, set wins.
  - a=2 EVENTS [15:0]: count of IDLE->ASSERT transitions. Several channels entering in one cycle add their popcount. Saturates at 0xFFFF. Any write clears it; a simultaneous increment is lost.
  - a=3 MASK [9:0]: irq enable mask. Read/write with RESET_STATUS_IRQ_EN; reads 0 and ignores writes without it.
  - a=4..7: read 0, writes ignored.
- rst_globl:
  - every channel to ASSERT, so rst_out = 10'h3FF on the following cycle
  - DONE=0, EVENTS=0, MASK=0, cnt=0
  - rst_globl takes priority over we and over rst_req.

## Timing
- Reset values after rst_globl: rst_out=10'h3FF, irq=0; spo follows a.
- rst_out is registered.
  - req sampled high at edge k -> rst_out=1 after edge k.
  - First low sample of req at edge m -> rst_out falls after edge m+HOLD_CYCLES. Total stretch is HOLD_CYCLES cycles beyond the request.
- DONE[i] rises on the same edge rst_out[i] falls.
- Read latency 0: spo is combinational from a and current register state.
- Write effect is visible on spo the cycle after we.
- Channels are fully independent; any combination may change on the same edge.

## Configuration
- RESET_STATUS_IRQ_EN defined:
  - MASK register and irq port exist.
  - irq is registered: irq <= |(DONE & MASK), one cycle after DONE/MASK change.
  - Cleared by W1C on DONE or by clearing MASK.
- RESET_STATUS_IRQ_EN undefined: no irq port, no MASK storage; a=3 reads 0.

## Test plan
- Apply rst_globl for 1 cycle, release with rst_req=10'h3FF, then drop rst_req to 0 with HOLD_CYCLES=16 -> rst_out stays 10'h3FF exactly 16 cycles after the first low sample, then 0. Reading a=0 then a=1 gives internal 0 and 10'h3FF respectively (spo byte-swapped, e.g. DONE=32'hFF030000).
- Pulse rst_req[8] (uart) for 1 cycle from IDLE -> rst_out[8] high 17 cycles total; EVENTS=1; DONE[8]=1.
- Re-raise rst_req[3] during HOLD at cnt=5 -> channel returns to ASSERT, no EVENTS increment, full 16-cycle hold restarts on the next drop.
- Write DONE clear mask 0x100 in the same cycle channel 8 completes -> DONE[8] stays 1. Preload EVENTS to 0xFFFE via repeated pulses, then pulse 3 channels together -> EVENTS=0xFFFF.
- With RESET_STATUS_IRQ_EN: MASK=0x001, complete channel 0 -> irq=1 one cycle after DONE[0] sets; W1C DONE[0] -> irq=0 next cycle. Assert rst_globl mid-HOLD -> rst_out=3FF, irq=0, EVENTS=0.

Source files
------------

// File: rtl/reset_status.sv
// reset_status: stretches each per-peripheral reset request by a minimum hold time and
// exposes STATUS/DONE/EVENTS(/MASK) on a byte-swapped bus. Optional irq: RESET_STATUS_IRQ_EN.
module reset_status #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_globl,
  input  logic [9:0]  rst_req,
  output logic [9:0]  rst_out,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo
`ifdef RESET_STATUS_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int NCH   = 10;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLD} state_e;

  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic           wr_done;
  logic           wr_events;
  logic [NCH-1:0] enter_vec;
  logic [NCH-1:0] finish_vec;
  logic [NCH-1:0] mask_rd;
  logic [NCH-1:0] done_q, done_d;
  logic [15:0]    events_q, events_d;
  logic [16:0]    events_sum;
  logic           unused_wdata;

  assign wdata        = {d[7:0], d[15:8], d[23:16], d[31:24]};
  assign wr_done      = we && (a == 3'd1);
  assign wr_events    = we && (a == 3'd2);
  assign unused_wdata = ^wdata[31:NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi = gi + 1) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             out_q, out_d;
      logic             enter;
      logic             finish;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enter   = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
          ST_IDLE: begin
            if (rst_req[gi]) begin
              state_d = ST_ASSERT;
              enter   = 1'b1;
            end
          end
          ST_ASSERT: begin
            if (!rst_req[gi]) begin
              state_d = ST_HOLD;
              cnt_d   = HOLD_LAST;
            end
          end
          ST_HOLD: begin
            // A re-raised request restarts the stretch without counting as a new event.
            if (rst_req[gi]) begin
              state_d = ST_ASSERT;
            end else if (cnt_q == '0) begin
              state_d = ST_IDLE;
              finish  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
        out_d = (state_d != ST_IDLE);
      end

      always_ff @(posedge clk) begin
        if (rst_globl) begin
          state_q <= ST_ASSERT;
          cnt_q   <= '0;
          out_q   <= 1'b1;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          out_q   <= out_d;
        end
      end

      assign rst_out[gi]    = out_q;
      assign enter_vec[gi]  = enter;
      assign finish_vec[gi] = finish;
    end
  endgenerate

  // Completion set beats a same-cycle W1C; an EVENTS write beats a same-cycle increment.
  always_comb begin
    done_d     = (done_q & ~(wr_done ? wdata[NCH-1:0] : '0)) | finish_vec;
    events_sum = {1'b0, events_q} + 17'($countones(enter_vec));
    if (wr_events) begin
      events_d = '0;
    end else if (events_sum[16]) begin
      events_d = 16'hFFFF;
    end else begin
      events_d = events_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_globl) begin
      done_q   <= '0;
      events_q <= '0;
    end else begin
      done_q   <= done_d;
      events_q <= events_d;
    end
  end

`ifdef RESET_STATUS_IRQ_EN
  logic           wr_mask;
  logic [NCH-1:0] mask_q, mask_d;
  logic           irq_q, irq_d;

  assign wr_mask = we && (a == 3'd3);

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) begin
      mask_d = wdata[NCH-1:0];
    end
    irq_d = |(done_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst_globl) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq     = irq_q;
  assign mask_rd = mask_q;
`else
  assign mask_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (a)
      3'd0:    rdata[NCH-1:0] = rst_out;
      3'd1:    rdata[NCH-1:0] = done_q;
      3'd2:    rdata[15:0]    = events_q;
      3'd3:    rdata[NCH-1:0] = mask_rd;
      default: rdata          = '0;
    endcase
  end

  assign spo = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};

endmodule

// File: tb/tb_reset_status.sv
// Randomized scoreboard bench for reset_status: a window-based reference model predicts
// rst_out/spo/irq each cycle; a monitor pops and compares on the falling edge.
module tb_reset_status;
  localparam int H   = 16;
  localparam int NCH = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_globl = 1'b1;
  logic [9:0]  rst_req   = '0;
  logic [2:0]  a         = '0;
  logic [31:0] d         = '0;
  logic        we        = 1'b0;
  logic [9:0]  rst_out;
  logic [31:0] spo;

  logic        s_globl = 1'b1;
  logic [9:0]  s_req   = '0;
  logic [2:0]  s_a     = 3'd2;
  logic [31:0] s_d     = '0;
  logic        s_we    = 1'b0;
  logic [9:0]  s_out;
  logic [31:0] s_spo;
  bit          sat_done = 1'b0;
`ifdef RESET_STATUS_IRQ_EN
  logic        irq;
  logic        s_irq;
`endif

  reset_status #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_globl(rst_globl), .rst_req(rst_req), .rst_out(rst_out),
    .a(a), .d(d), .we(we), .spo(spo)
`ifdef RESET_STATUS_IRQ_EN
    , .irq(irq)
`endif
  );

  // Short-hold instance used to reach EVENTS saturation in a reasonable number of cycles.
  reset_status #(.HOLD_CYCLES(1)) dut_sat (
    .clk(clk), .rst_globl(s_globl), .rst_req(s_req), .rst_out(s_out),
    .a(s_a), .d(s_d), .we(s_we), .spo(s_spo)
`ifdef RESET_STATUS_IRQ_EN
    , .irq(s_irq)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reference model: a channel is held while its last high request (or global reset)
  // lies within the last H edges.
  longint      edge_n = 0;
  longint      last_high [NCH];
  logic [9:0]  m_done   = '0;
  int          m_events = 0;
  logic [9:0]  m_mask   = '0;
  logic        m_irq    = 1'b0;
  bit          model_valid = 1'b0;

  function automatic logic [9:0] model_out();
    logic [9:0] v;
    for (int i = 0; i < NCH; i++) v[i] = ((edge_n - last_high[i]) <= H);
    return v;
  endfunction

  function automatic logic [31:0] read_exp(input logic [2:0] aa);
    logic [31:0] w;
    w = '0;
    case (aa)
      3'd0: w[9:0]  = model_out();
      3'd1: w[9:0]  = m_done;
      3'd2: w[15:0] = m_events[15:0];
      3'd3: w[9:0]  = m_mask;
      default: w = '0;
    endcase
    return swap(w);
  endfunction

  task automatic model_edge(input logic g, input logic [9:0] req, input logic [2:0] aa,
                            input logic [31:0] dd, input logic ww);
    logic [9:0]  set;
    logic [31:0] wi;
    logic        nirq;
    int          credits;
    edge_n++;
    if (g) begin
      for (int i = 0; i < NCH; i++) last_high[i] = edge_n;
      m_done = '0; m_events = 0; m_mask = '0; m_irq = 1'b0;
      model_valid = 1'b1;
      return;
    end
    nirq    = |(m_done & m_mask);
    credits = 0;
    set     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (req[i]) begin
        if ((edge_n - 1 - last_high[i]) > H) credits++;
        last_high[i] = edge_n;
      end else if ((edge_n - last_high[i]) == H + 1) begin
        set[i] = 1'b1;
      end
    end
    wi = swap(dd);
    m_done = (m_done & ~((ww && aa == 3'd1) ? wi[9:0] : 10'h0)) | set;
    if (ww && aa == 3'd2) m_events = 0;
    else m_events = (m_events + credits > 65535) ? 65535 : m_events + credits;
`ifdef RESET_STATUS_IRQ_EN
    if (ww && aa == 3'd3) m_mask = wi[9:0];
`endif
    m_irq = nirq;
  endtask

  typedef struct {
    logic [9:0]  out;
    logic [31:0] rd;
    logic        irq;
  } exp_t;
  exp_t sb [$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("sb_rst_out", {22'b0, rst_out}, {22'b0, mon_e.out});
      check("sb_spo", spo, mon_e.rd);
`ifdef RESET_STATUS_IRQ_EN
      check("sb_irq", {31'b0, irq}, {31'b0, mon_e.irq});
`endif
    end
  end

  // One bus cycle: drive inputs, queue the expected view before the edge, advance the model.
  task automatic cycle(input logic g, input logic [9:0] req, input logic [2:0] aa,
                       input logic [31:0] dd, input logic ww);
    exp_t e;
    rst_globl = g; rst_req = req; a = aa; d = dd; we = ww;
    if (model_valid) begin
      e.out = model_out();
      e.rd  = read_exp(aa);
      e.irq = m_irq;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    model_edge(g, req, aa, dd, ww);
  endtask

  task automatic measure(input int ch, output int n);
    n = 0;
    while (rst_out[ch] && n < 64) begin
      cycle(1'b0, 10'h0, 3'd2, 32'h0, 1'b0);
      n++;
    end
  endtask

  initial begin : main
    int          n;
    logic [9:0]  cur;
    logic [9:0]  flip;
    logic [31:0] rd;
    bit          g;
    @(posedge clk); #1;

    cycle(1'b1, 10'h3FF, 3'd0, 32'h0, 1'b0);
    check("reset_rst_out", {22'b0, rst_out}, 32'h3FF);
    check("reset_status_read", spo, 32'hFF030000);
`ifdef RESET_STATUS_IRQ_EN
    check("reset_irq", {31'b0, irq}, 32'h0);
`endif

    repeat (2) cycle(1'b0, 10'h3FF, 3'd0, 32'h0, 1'b0);
    cycle(1'b0, 10'h0, 3'd0, 32'h0, 1'b0);
    repeat (H - 1) cycle(1'b0, 10'h0, 3'd0, 32'h0, 1'b0);
    check("stretch_hold", {22'b0, rst_out}, 32'h3FF);
    cycle(1'b0, 10'h0, 3'd1, 32'h0, 1'b0);
    check("stretch_release", {22'b0, rst_out}, 32'h0);
    check("done_read", spo, 32'hFF030000);
    a = 3'd0; #1;
    check("status_idle_read", spo, 32'h0);

    // uart single-cycle pulse
    cycle(1'b0, 10'h0, 3'd1, swap(32'h3FF), 1'b1);
    cycle(1'b0, 10'h100, 3'd2, 32'h0, 1'b0);
    measure(8, n);
    check("uart_stretch", n, 32'd17);
    check("uart_events", swap(spo), 32'd1);
    a = 3'd1; #1;
    check("uart_done", swap(spo), 32'h100);

    // re-raise channel 3 while its counter is at 5
    cycle(1'b0, 10'h008, 3'd2, 32'h0, 1'b0);
    repeat (11) cycle(1'b0, 10'h0, 3'd2, 32'h0, 1'b0);
    cycle(1'b0, 10'h008, 3'd2, 32'h0, 1'b0);
    check("reraise_out", {31'b0, rst_out[3]}, 32'h1);
    check("reraise_no_credit", swap(spo), 32'd2);
    measure(3, n);
    check("reraise_restretch", n, H + 1);

    // W1C on DONE[8] in the very cycle channel 8 completes
    cycle(1'b0, 10'h0, 3'd1, swap(32'h3FF), 1'b1);
    cycle(1'b0, 10'h100, 3'd0, 32'h0, 1'b0);
    repeat (16) cycle(1'b0, 10'h0, 3'd0, 32'h0, 1'b0);
    cycle(1'b0, 10'h0, 3'd1, swap(32'h100), 1'b1);
    check("collide_release", {31'b0, rst_out[8]}, 32'h0);
    check("collide_done_kept", swap(spo), 32'h100);

`ifdef RESET_STATUS_IRQ_EN
    cycle(1'b0, 10'h0, 3'd1, swap(32'h3FF), 1'b1);
    cycle(1'b0, 10'h0, 3'd3, swap(32'h1), 1'b1);
    cycle(1'b0, 10'h001, 3'd3, 32'h0, 1'b0);
    check("mask_read", swap(spo), 32'h1);
    repeat (16) cycle(1'b0, 10'h0, 3'd1, 32'h0, 1'b0);
    cycle(1'b0, 10'h0, 3'd1, 32'h0, 1'b0);
    check("irq_done_set", swap(spo), 32'h1);
    check("irq_not_yet", {31'b0, irq}, 32'h0);
    cycle(1'b0, 10'h0, 3'd1, 32'h0, 1'b0);
    check("irq_set", {31'b0, irq}, 32'h1);
    cycle(1'b0, 10'h0, 3'd1, swap(32'h1), 1'b1);
    cycle(1'b0, 10'h0, 3'd1, 32'h0, 1'b0);
    check("irq_cleared", {31'b0, irq}, 32'h0);
`endif

    // global reset in the middle of a hold
    cycle(1'b0, 10'h0F0, 3'd2, 32'h0, 1'b0);
    repeat (5) cycle(1'b0, 10'h0, 3'd2, 32'h0, 1'b0);
    cycle(1'b1, 10'h0, 3'd2, 32'h0, 1'b1);
    check("midhold_reset_out", {22'b0, rst_out}, 32'h3FF);
    check("midhold_events", swap(spo), 32'h0);
`ifdef RESET_STATUS_IRQ_EN
    check("midhold_irq", {31'b0, irq}, 32'h0);
`endif

    // randomized traffic until the saturation run on the second instance is over
    cur = '0;
    for (int c = 0; c < 40000; c++) begin
      flip = 10'($urandom & $urandom & $urandom & $urandom);
      cur  = cur ^ flip;
      g    = ($urandom_range(0, 299) == 0);
      rd   = $urandom;
      cycle(g, cur, 3'($urandom_range(0, 7)), rd, ($urandom_range(0, 3) == 0));
      if (c >= 3000 && sat_done) break;
    end
    if (!sat_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL sat_timeout: saturation run did not finish within the cycle budget");
    end

    @(negedge clk); #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // EVENTS saturation on the HOLD_CYCLES=1 instance: each pulse costs three edges.
  initial begin : sat
    @(posedge clk); #1;
    s_globl = 1'b0; s_req = '0; s_a = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 6553; p++) begin
      s_req = 10'h3FF; @(posedge clk); #1;
      s_req = 10'h0;   repeat (2) @(posedge clk);
      #1;
    end
    check("sat_preload", swap(s_spo), 32'd65530);
    s_req = 10'h00F; @(posedge clk); #1;
    s_req = 10'h0;   repeat (2) @(posedge clk);
    #1;
    check("sat_fffe", swap(s_spo), 32'h0000FFFE);
    s_req = 10'h007; @(posedge clk); #1;
    s_req = 10'h0;   repeat (2) @(posedge clk);
    #1;
    check("sat_clamp", swap(s_spo), 32'h0000FFFF);
    s_req = 10'h3FF; @(posedge clk); #1;
    s_req = 10'h0;   repeat (2) @(posedge clk);
    #1;
    check("sat_stay", swap(s_spo), 32'h0000FFFF);
    s_req = 10'h3FF; s_we = 1'b1; s_d = $urandom; @(posedge clk); #1;
    s_req = 10'h0;   s_we = 1'b0;
    check("events_clear_beats_inc", swap(s_spo), 32'h0);
    repeat (2) @(posedge clk);
    sat_done = 1'b1;
  end

endmodule
